// File: rtl/ctrlport_window_decoder_if.sv
// ctrlport_window_decoder_if
//   Bundles the upstream (single slave-side) control-port and the
//   NUM_WINDOWS downstream (master-side) control-ports of the window decoder.
//   Signal names match the decoder's historic port names.
//
//   modport slave  : the decoder's view. It receives s_* requests, returns s_*
//                    responses, issues m_* requests and receives m_* responses.
//   modport master : the environment's view. This is the upstream requester
//                    together with the downstream endpoints.
interface ctrlport_window_decoder_if #(
  parameter int unsigned NUM_WINDOWS = 2
);
  logic                      s_ctrlport_req_wr;
  logic                      s_ctrlport_req_rd;
  logic [19:0]               s_ctrlport_req_addr;
  logic [31:0]               s_ctrlport_req_data;
  logic [3:0]                s_ctrlport_req_byte_en;
  logic                      s_ctrlport_resp_ack;
  logic [1:0]                s_ctrlport_resp_status;
  logic [31:0]               s_ctrlport_resp_data;

  logic [NUM_WINDOWS-1:0]    m_ctrlport_req_wr;
  logic [NUM_WINDOWS-1:0]    m_ctrlport_req_rd;
  logic [20*NUM_WINDOWS-1:0] m_ctrlport_req_addr;
  logic [32*NUM_WINDOWS-1:0] m_ctrlport_req_data;
  logic [4*NUM_WINDOWS-1:0]  m_ctrlport_req_byte_en;
  logic [NUM_WINDOWS-1:0]    m_ctrlport_resp_ack;
  logic [2*NUM_WINDOWS-1:0]  m_ctrlport_resp_status;
  logic [32*NUM_WINDOWS-1:0] m_ctrlport_resp_data;

  modport slave (
    input  s_ctrlport_req_wr, s_ctrlport_req_rd, s_ctrlport_req_addr,
           s_ctrlport_req_data, s_ctrlport_req_byte_en,
    output s_ctrlport_resp_ack, s_ctrlport_resp_status, s_ctrlport_resp_data,
    output m_ctrlport_req_wr, m_ctrlport_req_rd, m_ctrlport_req_addr,
           m_ctrlport_req_data, m_ctrlport_req_byte_en,
    input  m_ctrlport_resp_ack, m_ctrlport_resp_status, m_ctrlport_resp_data
  );

  modport master (
    output s_ctrlport_req_wr, s_ctrlport_req_rd, s_ctrlport_req_addr,
           s_ctrlport_req_data, s_ctrlport_req_byte_en,
    input  s_ctrlport_resp_ack, s_ctrlport_resp_status, s_ctrlport_resp_data,
    input  m_ctrlport_req_wr, m_ctrlport_req_rd, m_ctrlport_req_addr,
           m_ctrlport_req_data, m_ctrlport_req_byte_en,
    output m_ctrlport_resp_ack, m_ctrlport_resp_status, m_ctrlport_resp_data
  );
endinterface

// File: rtl/ctrlport_window_decoder.sv
// ctrlport_window_decoder
//   Routes single-outstanding control-port transactions from one slave port
//   to one of NUM_WINDOWS master ports by address window. It returns the
//   selected port's registered response. A CMDERR response (status 2'b01,
//   data 0) is returned for addresses outside every window, and also when no
//   ack arrives within TIMEOUT_CYCLES (0 disables the timeout).
//
//   Ports:
//     ctrlport_clk : clock
//     ctrlport_rst : asynchronous, active-high reset
//     bus          : ctrlport_window_decoder_if.slave (s_* upstream, m_* downstream)
module ctrlport_window_decoder #(
  parameter int unsigned               NUM_WINDOWS    = 2,
  parameter logic [NUM_WINDOWS*20-1:0] BASE_ADDRESS   = {20'h00100, 20'h00000},
  parameter logic [NUM_WINDOWS*20-1:0] WINDOW_SIZE    = {20'h00100, 20'h00100},
  parameter bit                        RELATIVE_ADDR  = 1'b0,
  parameter logic [15:0]               TIMEOUT_CYCLES = 16'd1023
) (
  input  logic                       ctrlport_clk,
  input  logic                       ctrlport_rst,
  ctrlport_window_decoder_if.slave   bus
);

  localparam int unsigned SEL_W = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ERR
  } state_t;

  state_t                    state, state_nxt;
  logic [15:0]               cnt, cnt_nxt;
  logic [SEL_W-1:0]          sel, sel_nxt;

  logic [NUM_WINDOWS-1:0]    m_wr_q, m_wr_nxt;
  logic [NUM_WINDOWS-1:0]    m_rd_q, m_rd_nxt;
  logic [20*NUM_WINDOWS-1:0] m_addr_q, m_addr_nxt;
  logic [32*NUM_WINDOWS-1:0] m_data_q, m_data_nxt;
  logic [4*NUM_WINDOWS-1:0]  m_be_q, m_be_nxt;
  logic                      s_ack_q, s_ack_nxt;
  logic [1:0]                s_status_q, s_status_nxt;
  logic [31:0]               s_data_q, s_data_nxt;

  logic                      hit;
  logic [SEL_W-1:0]          hit_idx;
  logic [19:0]               hit_base;
  logic [20:0]               lo21, hi21;
  logic [19:0]               fwd_addr;

  // Window decode. The 21-bit compare keeps a window that ends exactly at
  // 2^20 from wrapping. Scanning upward with a found flag gives priority to
  // the lowest index.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    lo21     = '0;
    hi21     = '0;
    for (int unsigned i = 0; i < NUM_WINDOWS; i++) begin
      lo21 = {1'b0, BASE_ADDRESS[20*i +: 20]};
      hi21 = lo21 + {1'b0, WINDOW_SIZE[20*i +: 20]};
      if (!hit && ({1'b0, bus.s_ctrlport_req_addr} >= lo21) &&
          ({1'b0, bus.s_ctrlport_req_addr} < hi21)) begin
        hit      = 1'b1;
        hit_idx  = SEL_W'(i);
        hit_base = BASE_ADDRESS[20*i +: 20];
      end
    end
    fwd_addr = RELATIVE_ADDR ? (bus.s_ctrlport_req_addr - hit_base)
                             : bus.s_ctrlport_req_addr;
  end

  // Next-state and next registered outputs. Every output is registered, so
  // this block computes what each register loads on the next edge.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sel_nxt      = sel;
    m_wr_nxt     = '0;
    m_rd_nxt     = '0;
    m_addr_nxt   = m_addr_q;
    m_data_nxt   = m_data_q;
    m_be_nxt     = m_be_q;
    s_ack_nxt    = 1'b0;
    s_status_nxt = '0;
    s_data_nxt   = '0;

    case (state)
      ST_IDLE: begin
        if (bus.s_ctrlport_req_wr || bus.s_ctrlport_req_rd) begin
          if (hit) begin
            m_wr_nxt[hit_idx]             = bus.s_ctrlport_req_wr;
            m_rd_nxt[hit_idx]             = bus.s_ctrlport_req_rd;
            m_addr_nxt[20*hit_idx +: 20]  = fwd_addr;
            m_data_nxt[32*hit_idx +: 32]  = bus.s_ctrlport_req_data;
            m_be_nxt[4*hit_idx +: 4]      = bus.s_ctrlport_req_byte_en;
            sel_nxt                       = hit_idx;
            cnt_nxt                       = 16'd1;
            state_nxt                     = ST_BUSY;
          end else begin
            s_ack_nxt    = 1'b1;
            s_status_nxt = 2'b01;
            state_nxt    = ST_ERR;
          end
        end
      end
      ST_BUSY: begin
        // A master ack takes precedence over a timeout that expires in the same cycle.
        if (bus.m_ctrlport_resp_ack[sel]) begin
          s_ack_nxt    = 1'b1;
          s_status_nxt = bus.m_ctrlport_resp_status[2*sel +: 2];
          s_data_nxt   = bus.m_ctrlport_resp_data[32*sel +: 32];
          cnt_nxt      = '0;
          state_nxt    = ST_IDLE;
        end else if ((TIMEOUT_CYCLES != 16'd0) && (cnt == TIMEOUT_CYCLES)) begin
          s_ack_nxt    = 1'b1;
          s_status_nxt = 2'b01;
          cnt_nxt      = '0;
          state_nxt    = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      ST_ERR: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ctrlport_clk or posedge ctrlport_rst) begin
    if (ctrlport_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sel        <= '0;
      m_wr_q     <= '0;
      m_rd_q     <= '0;
      m_addr_q   <= '0;
      m_data_q   <= '0;
      m_be_q     <= '0;
      s_ack_q    <= 1'b0;
      s_status_q <= '0;
      s_data_q   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel        <= sel_nxt;
      m_wr_q     <= m_wr_nxt;
      m_rd_q     <= m_rd_nxt;
      m_addr_q   <= m_addr_nxt;
      m_data_q   <= m_data_nxt;
      m_be_q     <= m_be_nxt;
      s_ack_q    <= s_ack_nxt;
      s_status_q <= s_status_nxt;
      s_data_q   <= s_data_nxt;
    end
  end

  assign bus.m_ctrlport_req_wr      = m_wr_q;
  assign bus.m_ctrlport_req_rd      = m_rd_q;
  assign bus.m_ctrlport_req_addr    = m_addr_q;
  assign bus.m_ctrlport_req_data    = m_data_q;
  assign bus.m_ctrlport_req_byte_en = m_be_q;
  assign bus.s_ctrlport_resp_ack    = s_ack_q;
  assign bus.s_ctrlport_resp_status = s_status_q;
  assign bus.s_ctrlport_resp_data   = s_data_q;

endmodule

// File: doc/ctrlport_window_decoder.md
CTRLPORT_WINDOW_DECODER -- requirements
Module: ctrlport_window_decoder

Interface
REQ-001 SHALL have parameter NUM_WINDOWS, default 2, number of master ports/windows (1..16).
REQ-002 SHALL have parameter BASE_ADDRESS, default {20'h00100, 20'h00000}, packed NUM_WINDOWS*20 bits; window i base at bits [20*i +: 20].
REQ-003 SHALL have parameter WINDOW_SIZE, default {20'h00100, 20'h00100}, packed NUM_WINDOWS*20 bits; window i covers [base_i, base_i+size_i-1].
REQ-004 SHALL have parameter RELATIVE_ADDR, default 0; 1 = forwarded address is addr-base_i, 0 = unchanged.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1023, 16-bit; 0 disables timeout.
REQ-006 SHALL have ports ctrlport_clk in 1 clock; ctrlport_rst in 1; reset is asynchronous and active-high.
REQ-007 SHALL have slave ports s_ctrlport_req_wr in 1, s_ctrlport_req_rd in 1, s_ctrlport_req_addr in 20, s_ctrlport_req_data in 32, s_ctrlport_req_byte_en in 4.
REQ-008 SHALL have slave response ports s_ctrlport_resp_ack out 1, s_ctrlport_resp_status out 2, s_ctrlport_resp_data out 32.
REQ-009 SHALL have master request ports m_ctrlport_req_wr out N, m_ctrlport_req_rd out N, m_ctrlport_req_addr out 20*N, m_ctrlport_req_data out 32*N, m_ctrlport_req_byte_en out 4*N (N=NUM_WINDOWS).
REQ-010 SHALL have master response ports m_ctrlport_resp_ack in N, m_ctrlport_resp_status in 2*N, m_ctrlport_resp_data in 32*N.

Function
REQ-011 SHALL decode window hit as base_i <= addr < base_i+size_i, computed in 21-bit arithmetic (no wrap); lowest index wins on overlap.
REQ-012 SHALL implement FSM IDLE, BUSY, ERR; reset state IDLE.
REQ-013 SHALL, in IDLE on (req_wr|req_rd) with a hit on window k, pulse m_ctrlport_req_wr/rd[k] exactly one cycle, registered (one cycle after slave request), then enter BUSY.
REQ-014 SHALL drive req_addr/data/byte_en of the selected port with the captured request; unselected ports get wr=rd=0 and hold last values.
REQ-015 SHALL, in IDLE on request with no hit, enter ERR and assert s_ctrlport_resp_ack next cycle with status 2'b01 (CMDERR), data 0, then return to IDLE.
REQ-016 SHALL, in BUSY, respond only to m_ctrlport_resp_ack[k] of the selected window; acks on other ports are ignored.
REQ-017 SHALL register the response: s_ctrlport_resp_ack pulses one cycle after m_ctrlport_resp_ack[k], carrying that port's status and data; FSM returns to IDLE same cycle.
REQ-018 SHALL count BUSY cycles from 1; when count reaches TIMEOUT_CYCLES without ack (TIMEOUT_CYCLES!=0), pulse s_ctrlport_resp_ack with status 2'b01, data 0, and return to IDLE.
REQ-019 SHALL discard a master ack arriving after timeout; an ack in the same cycle as timeout expiry takes precedence over the timeout error.
REQ-020 SHALL ignore (drop, never ack) slave requests arriving while BUSY or ERR.
REQ-021 SHALL forward simultaneous wr and rd as one transaction with both flags set on the selected port.
REQ-022 SHALL hold s_ctrlport_resp_status/data at 0 whenever s_ctrlport_resp_ack is 0.

Reset
REQ-023 SHALL, on ctrlport_rst assertion, asynchronously force FSM to IDLE, timeout counter to 0, and all ack/wr/rd outputs, status, data, addr and byte_en outputs to 0.
REQ-024 SHALL, on reset mid-transaction, produce no slave ack for the aborted request and ignore any later master ack for it.

Verification
REQ-025 Write addr 0x00104, data 0xDEADBEEF, defaults -> cycle+1 m_req_wr[1]=1, addr 0x00104; m_resp_ack[1] at +4 -> s_resp_ack at +5, status 00.
REQ-026 RELATIVE_ADDR=1, read 0x00120 -> m_req_rd[1], addr 0x00020; m_resp_data 0x12345678 returned unchanged on slave side.
REQ-027 Read 0x00300 (no hit) -> no master strobe; s_resp_ack next cycle, status 01, data 0.
REQ-028 TIMEOUT_CYCLES=8, read window 0, no ack -> s_resp_ack status 01 after 8 BUSY cycles; late m_resp_ack[0] ignored; next request served normally.
REQ-029 Spurious m_resp_ack[0] while BUSY on window 1, plus second slave request while BUSY -> both ignored; only window 1 ack completes.
REQ-030 Assert ctrlport_rst while BUSY -> all outputs 0 immediately; post-reset request completes normally, no stale ack.
